// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus a
// W-cycle shift-add multiply that stalls issue while it runs.
//
// state | meaning
// IDLE  | no result held, ready for an op
// MUL   | shift-add multiply iterating, issue stalled
// DONE  | result held on outputs until the consumer takes it
module seq_alu #(
  parameter int W    = 8,
  parameter int IMMW = 3
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [3:0]      Aluop,
  input  logic [IMMW-1:0] Imm,
  input  logic [W-1:0]    DatA,
  input  logic [W-1:0]    DatB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [W-1:0]    Rslt,
  output logic            Zero,
  output logic            Par,
  output logic            Jen,
  output logic            SCo,
  output logic            Busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] W_MOD = W'(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [W-1:0]   r_rslt;
  logic           r_zero, r_par, r_jen, r_sco;
  logic [2*W-1:0] r_mcand, r_acc;
  logic [W-1:0]   r_mplr;
  logic [CW-1:0]  r_cnt;

  logic           w_accept, w_is_mul, w_mul_last;
  logic [W-1:0]   w_rslt, w_pop, w_shl, w_shr, w_rot_amt;
  logic           w_jen, w_sco;
  logic [W:0]     w_add, w_sub, w_addi, w_subi;
  logic [IMMW-1:0] w_imm_mag;
  logic [2*W-1:0] w_rot2, w_acc_nxt;

  assign w_accept   = InValid && InReady;
  assign w_is_mul   = (Aluop == 4'b1100);
  assign w_mul_last = (r_cnt == CW'(1));

  assign w_add  = {1'b0, DatA} + {1'b0, DatB};
  assign w_sub  = {1'b0, DatA} - {1'b0, DatB};
  assign w_addi = {1'b0, DatA} + (W+1)'(Imm);
  assign w_subi = {1'b0, DatA} - (W+1)'(Imm);

  // Negative immediates shift right by their magnitude; oversize shifts fall out as 0.
  assign w_imm_mag = Imm[IMMW-1] ? (~Imm + 1'b1) : Imm;
  assign w_shl     = DatA << w_imm_mag;
  assign w_shr     = DatA >> w_imm_mag;

  assign w_rot_amt = DatB % W_MOD;
  assign w_rot2    = {DatA, DatA} << w_rot_amt;

  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) w_pop = w_pop + W'(DatA[i]);
  end

  always_comb begin
    w_rslt = '0;
    w_jen  = 1'b0;
    w_sco  = 1'b0;
    case (Aluop)
      4'b0000: w_rslt = DatA ^ DatB;
      4'b0001: {w_sco, w_rslt} = w_add;
      4'b0010: {w_sco, w_rslt} = w_sub;
      4'b0011: w_rslt = (DatA == '0) ? W'(1) : '0;
      4'b0100: w_rslt = ~DatA;
      4'b0101: w_rslt = w_pop;
      4'b0110: w_jen = (DatA < DatB);
      4'b0111: w_jen = ($signed(DatA) < $signed(DatB));
      4'b1000: w_rslt = DatA;
      4'b1001: w_rslt = Imm[IMMW-1] ? w_shr : w_shl;
      4'b1010: {w_sco, w_rslt} = w_addi;
      4'b1011: {w_sco, w_rslt} = w_subi;
      4'b1101: w_rslt = w_rot2[2*W-1:W];
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE: if (OutReady) begin
        if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    InReady  = (r_state == S_IDLE) || ((r_state == S_DONE) && OutReady);
    OutValid = (r_state == S_DONE);
    Busy     = (r_state == S_MUL);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rslt  <= '0;
      r_zero  <= 1'b0;
      r_par   <= 1'b0;
      r_jen   <= 1'b0;
      r_sco   <= 1'b0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand <= {{W{1'b0}}, DatA};
        r_mplr  <= DatB;
        r_acc   <= '0;
        r_cnt   <= CW'(W);
      end else begin
        r_rslt <= w_rslt;
        r_zero <= (w_rslt == '0);
        r_par  <= ^w_rslt;
        r_jen  <= w_jen;
        r_sco  <= w_sco;
      end
    end else if (r_state == S_MUL) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt - CW'(1);
      // Final iteration: publish the product straight from the adder output.
      if (w_mul_last) begin
        r_rslt <= w_acc_nxt[W-1:0];
        r_zero <= (w_acc_nxt[W-1:0] == '0);
        r_par  <= ^w_acc_nxt[W-1:0];
        r_jen  <= 1'b0;
        r_sco  <= |w_acc_nxt[2*W-1:W];
      end
    end
  end

  assign Rslt = r_rslt;
  assign Zero = r_zero;
  assign Par  = r_par;
  assign Jen  = r_jen;
  assign SCo  = r_sco;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, a negedge
// monitor compares whatever the DUT presents while OutValid is high.
module tb_seq_alu;
  localparam int W    = 8;
  localparam int IMMW = 3;

  localparam logic [3:0] OP_XOR = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010,
                         OP_ISZ = 4'b0011, OP_NOT = 4'b0100, OP_POP = 4'b0101,
                         OP_CMPU = 4'b0110, OP_CMPS = 4'b0111, OP_MOV = 4'b1000,
                         OP_SHF = 4'b1001, OP_ADDI = 4'b1010, OP_SUBI = 4'b1011,
                         OP_MUL = 4'b1100, OP_ROT = 4'b1101, OP_R0 = 4'b1110,
                         OP_R1 = 4'b1111;

  typedef struct packed {
    logic [W-1:0] rslt;
    logic         zero;
    logic         par;
    logic         jen;
    logic         sco;
  } exp_t;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            InValid = 1'b0;
  logic            InReady;
  logic [3:0]      Aluop = '0;
  logic [IMMW-1:0] Imm = '0;
  logic [W-1:0]    DatA = '0;
  logic [W-1:0]    DatB = '0;
  logic            OutValid;
  logic            OutReady = 1'b0;
  logic [W-1:0]    Rslt;
  logic            Zero, Par, Jen, SCo, Busy;

  int     n_pass = 0;
  int     n_total = 0;
  exp_t   q_exp[$];
  string  q_name[$];
  exp_t   mon_e;
  string  mon_n;

  seq_alu #(.W(W), .IMMW(IMMW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .Aluop(Aluop), .Imm(Imm), .DatA(DatA), .DatB(DatB),
    .OutValid(OutValid), .OutReady(OutReady), .Rslt(Rslt),
    .Zero(Zero), .Par(Par), .Jen(Jen), .SCo(SCo), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%h, want 0x%h", nm, act, req);
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic jen, input logic sco);
    exp_t e;
    e.rslt = r;
    e.zero = (r == '0);
    e.par  = ^r;
    e.jen  = jen;
    e.sco  = sco;
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Reset_n && OutValid) begin
      if (q_exp.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: Rslt=0x%h with nothing pending", Rslt);
      end else begin
        chk(q_name[0], {20'd0, Rslt, Zero, Par, Jen, SCo}, {20'd0, q_exp[0]});
        if (OutReady) begin
          mon_e = q_exp.pop_front();
          mon_n = q_name.pop_front();
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [IMMW-1:0] imm,
                       input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit done;
    done = 0;
    Aluop = op; Imm = imm; DatA = a; DatB = b; InValid = 1'b1;
    q_exp.push_back(e);
    q_name.push_back(nm);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (InReady) begin
        @(posedge Clk);
        #1;
        done = 1;
      end
    end
    InValid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout_%s: InReady stayed 0, want 1", nm);
    end
  endtask

  task automatic mul_watch();
    for (int i = 0; i < W; i++) begin
      @(negedge Clk);
      chk("mul_busy_stall", {29'd0, Busy, InReady, OutValid}, 32'b100);
    end
    @(negedge Clk);
    chk("mul_done", {30'd0, Busy, OutValid}, 32'b01);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_rslt", {24'd0, Rslt}, 32'd0);
    chk("rst_flags", {28'd0, Zero, Par, Jen, SCo}, 32'd0);
    chk("rst_valid_busy", {30'd0, OutValid, Busy}, 32'd0);
    chk("rst_inready", {31'd0, InReady}, 32'd1);
    @(negedge Clk);
    Reset_n = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk);
    #1;

    issue("add_wrap",   OP_ADD,  3'd0, 8'hFF, 8'h01, mk(8'h00, 0, 1));
    issue("xor",        OP_XOR,  3'd0, 8'h0F, 8'h3C, mk(8'h33, 0, 0));
    issue("sub",        OP_SUB,  3'd0, 8'h10, 8'h01, mk(8'h0F, 0, 0));
    issue("iszero_0",   OP_ISZ,  3'd0, 8'h00, 8'h77, mk(8'h01, 0, 0));
    issue("iszero_5",   OP_ISZ,  3'd0, 8'h05, 8'h00, mk(8'h00, 0, 0));
    issue("not",        OP_NOT,  3'd0, 8'hA5, 8'h00, mk(8'h5A, 0, 0));
    issue("mov",        OP_MOV,  3'd0, 8'h3C, 8'hFF, mk(8'h3C, 0, 0));
    issue("shf_m1",     OP_SHF,  3'b111, 8'h80, 8'h00, mk(8'h40, 0, 0));
    issue("shf_p3",     OP_SHF,  3'b011, 8'h81, 8'h00, mk(8'h08, 0, 0));
    issue("shf_m4",     OP_SHF,  3'b100, 8'hF0, 8'h00, mk(8'h0F, 0, 0));
    issue("cmps_lt",    OP_CMPS, 3'd0, 8'h80, 8'h01, mk(8'h00, 1, 0));
    issue("cmpu_ge",    OP_CMPU, 3'd0, 8'h80, 8'h01, mk(8'h00, 0, 0));
    issue("cmps_ge",    OP_CMPS, 3'd0, 8'h01, 8'h80, mk(8'h00, 0, 0));
    issue("cmpu_lt",    OP_CMPU, 3'd0, 8'h01, 8'h80, mk(8'h00, 1, 0));
    issue("addi_carry", OP_ADDI, 3'd3, 8'hFE, 8'h00, mk(8'h01, 0, 1));
    issue("subi_borrow",OP_SUBI, 3'd5, 8'h02, 8'h00, mk(8'hFD, 0, 1));
    issue("subi_zero",  OP_SUBI, 3'd7, 8'h07, 8'h00, mk(8'h00, 0, 0));
    issue("rot_9",      OP_ROT,  3'd0, 8'h81, 8'h09, mk(8'h03, 0, 0));
    issue("rot_4",      OP_ROT,  3'd0, 8'h12, 8'h04, mk(8'h21, 0, 0));
    issue("addc_pre",   OP_ADD,  3'd0, 8'hFF, 8'hFF, mk(8'hFE, 0, 1));
    issue("rsvd_e",     OP_R0,   3'd7, 8'hFF, 8'hFF, mk(8'h00, 0, 0));
    issue("rsvd_f",     OP_R1,   3'd7, 8'h5A, 8'hA5, mk(8'h00, 0, 0));

    issue("mul_10x11",  OP_MUL,  3'd0, 8'h10, 8'h11, mk(8'h10, 0, 1));
    mul_watch();

    OutReady = 1'b0;
    issue("pop_b5_hold", OP_POP, 3'd0, 8'hB5, 8'h00, mk(8'h05, 0, 0));
    q_exp.push_back(mk(8'hF0, 0, 0));
    q_name.push_back("xor_after_hold");
    Aluop = OP_XOR; DatA = 8'h0F; DatB = 8'hFF; Imm = '0; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_inready_low", {31'd0, InReady}, 32'd0);
    end
    @(posedge Clk);
    #1;
    OutReady = 1'b1;
    @(negedge Clk);
    chk("bp_release_inready", {31'd0, InReady}, 32'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;

    issue("mul_aborted", OP_MUL, 3'd0, 8'h10, 8'h11, mk(8'h10, 0, 1));
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    mon_e = q_exp.pop_back();
    mon_n = q_name.pop_back();
    #2;
    chk("abort_rslt", {24'd0, Rslt}, 32'd0);
    chk("abort_flags", {28'd0, Zero, Par, Jen, SCo}, 32'd0);
    chk("abort_ctrl", {29'd0, OutValid, Busy, InReady}, 32'b001);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    issue("sub_after_abort", OP_SUB, 3'd0, 8'h03, 8'h05, mk(8'hFE, 0, 1));
    issue("mul_0fx0f", OP_MUL, 3'd0, 8'h0F, 8'h0F, mk(8'hE1, 0, 0));
    mul_watch();
    issue("pop_ff", OP_POP, 3'd0, 8'hFF, 8'h00, mk(8'h08, 0, 0));

    repeat (4) @(posedge Clk);
    #1;
    chk("queue_drained", q_exp.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised ALU with a valid/ready handshake on both input and output. It adds a multi-cycle shift-add multiply and a signed compare, and produces fully defined flag outputs on every operation. It sits between the decode stage and register-file writeback, and stalls the upstream issue through `InReady` while a multiply is in flight.

## Interface
- `W`, 8: datapath width in bits, ≥4.
- `IMMW`, 3: immediate width in bits, ≥2, <W.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  operation presented on `Aluop`/`Imm`/`DatA`/`DatB`.
- `InReady`  out  1  block can accept an operation this cycle.
- `Aluop`  in  4  opcode.
- `Imm`  in  IMMW  immediate.
- `DatA`, `DatB`  in  W each  operands.
- `OutValid`  out  1  result registers hold a completed operation.
- `OutReady`  in  1  consumer takes the result this cycle.
- `Rslt`  out  W  result.
- `Zero`  out  1  `Rslt`==0.
- `Par`  out  1  XOR-reduction of `Rslt`.
- `Jen`  out  1  compare outcome.
- `SCo`  out  1  carry, borrow or overflow.
- `Busy`  out  1  multiply in progress.

One clock. Reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, MUL, DONE.
- **Accept:** a transfer happens when `InValid`&&`InReady`. `InReady` = (state==IDLE) || (state==DONE && `OutReady`).
- **Opcodes:** unlisted outputs are 0. Sums use W+1 bits; `SCo`=bit W.
  - 0000: `Rslt`=A^B.
  - 0001: `Rslt`=A+B, `SCo`=carry.
  - 0010: `Rslt`=A−B, `SCo`=borrow (1 iff A<B unsigned).
  - 0011: `Rslt`=1 if A==0, else 0.
  - 0100: `Rslt`=~A.
  - 0101: `Rslt`=popcount(A).
  - 0110: `Jen`=(A<B) unsigned, `Rslt`=0.
  - 0111: `Jen`=(A<B) signed two's complement, `Rslt`=0.
  - 1000: `Rslt`=A.
  - 1001: `Imm` is signed. Imm≥0: A<<Imm. Imm<0: logical A>>|Imm|. Shift ≥W gives 0.
  - 1010: `Rslt`=A+zext(Imm), `SCo`=carry.
  - 1011: `Rslt`=A−zext(Imm), `SCo`=borrow.
  - 1100: `Rslt`=low W bits of A×B (unsigned), `SCo`=1 iff the high W bits ≠0.
  - 1101: `Rslt`=A rotated left by B mod W.
  - 1110, 1111: reserved. `Rslt`=0, `Zero`=1, other flags 0.
- **Flags:** `Zero` and `Par` are derived from the final `Rslt` and registered with it. All flags are defined for every opcode; no latches.
- **Single-cycle ops** (all except 1100): on accept, the result and flags are registered and state goes to DONE.
- **Multiply** (1100): on accept, latch A, B and clear the 2W-bit accumulator; set counter=W and go to MUL.
  - Each MUL cycle: if multiplier LSB is 1, add the shifted multiplicand; shift both; decrement the counter.
  - When the counter reaches 0, register the result and go to DONE.
  - `Busy`=1 only in MUL.
- **DONE:** `OutValid`=1. Outputs hold stable until `OutReady`.
  - `OutReady` with a new accept in the same cycle: load the next op (DONE again, or MUL for a multiply).
  - `OutReady` without a new accept: go to IDLE.
- **IDLE and MUL:** `OutValid`=0. `Rslt` and flags keep their last values; they are don't-care to consumers.
- **`OutReady` outside DONE:** ignored.
- **`InValid` while `InReady`=0:** ignored. Upstream must hold the operation.

## Timing
- **Reset** (async assert, synchronous-safe deassert): state=IDLE; `Rslt`=0, `Zero`=0, `Par`=0, `Jen`=0, `SCo`=0; `OutValid`=0, `Busy`=0, counter=0; `InReady`=1.
- **Single-cycle latency:** accept at edge N → `OutValid`=1 after edge N.
- **Multiply latency:** accept at edge N → `Busy` after edge N; `OutValid` after edge N+W. At W=8 that is 8 cycles; for W=8 the total is W+1 cycles from presenting the op to result visible.
- **Throughput:** one single-cycle op per cycle while `OutReady` is held high.
- **Reset mid-multiply:** operation is dropped, no `OutValid` is produced, and the next accept behaves as from reset.

## Test plan
- **Add with wrap:** reset, then ADD A=0xFF B=0x01 → next cycle `Rslt`=0x00, `SCo`=1, `Zero`=1, `Par`=0, `OutValid`=1.
- **Multiply:** MUL A=0x10 B=0x11 → `Busy` for 8 cycles, then `Rslt`=0x10, `SCo`=1. `InReady`=0 throughout MUL.
- **Shifts:** SHIFT A=0x80 Imm=3'b111 → 0x40. SHIFT A=0x81 Imm=3'b011 → 0x08. SHIFT Imm=3'b100 on 0xF0 → 0x0F.
- **Compares:** A=0x80 B=0x01: op 0111 → `Jen`=1; op 0110 → `Jen`=0; `Rslt`=0, `Zero`=1 in both.
- **Backpressure:** POPCOUNT A=0xB5 with `OutReady` low for 5 cycles → `Rslt`=0x05, `Par`=0, stable all 5 cycles, `InReady`=0. Then `OutReady`=1 with XOR 0x0F^0xFF queued → next cycle `Rslt`=0xF0.
- **Reset abort:** assert `Reset_n`=0 in the 4th MUL cycle → all outputs 0, `InReady`=1. After release, SUB 0x03−0x05 → `Rslt`=0xFE, `SCo`=1.
